// File: rtl/pc_branch_unit.sv
// pc_branch_unit: flag register, program counter and branch resolution.
// Latches ALU Z/N flags, resolves JUMP/BRZ/BRN/BRNZ against them, redirects
// the PC on a taken branch and raises a flush window for wrong-path slots.
//
// Build option: PC_BRANCH_FLAG_BYPASS_EN forwards z_in_i/n_in_i into the
// branch condition when flag_we_i is set in the same cycle as the branch.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_RUN   | normal sequencing, branches resolved when en_i=1
// ST_FLUSH | wrong-path squash window, branches ignored, counter runs
// ST_HALT  | sequencing stopped, pc/flags frozen until rst_ni

module pc_branch_unit #(
  parameter int unsigned          PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC     = '0,
  parameter int unsigned          FLUSH_CYCLES = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                flag_we_i,
  input  logic                z_in_i,
  input  logic                n_in_i,
  input  logic                br_valid_i,
  input  logic [2:0]          br_op_i,
  input  logic [PC_WIDTH-1:0] target_i,
  input  logic                halt_req_i,
  output logic [PC_WIDTH-1:0] pc_o,
  output logic                z_flag_o,
  output logic                n_flag_o,
  output logic                taken_o,
  output logic                flush_o,
  output logic                halted_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  localparam logic [2:0] OP_JUMP = 3'b001;
  localparam logic [2:0] OP_BRZ  = 3'b010;
  localparam logic [2:0] OP_BRN  = 3'b011;
  localparam logic [2:0] OP_BRNZ = 3'b100;

  localparam logic [PC_WIDTH-1:0] PC_ONE     = PC_WIDTH'(1);
  localparam logic [3:0]          FLUSH_LOAD = 4'(FLUSH_CYCLES);
  localparam logic                HAS_FLUSH  = (FLUSH_CYCLES != 0);

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  z_q, z_d;
  logic                  n_q, n_d;
  logic                  taken_q, taken_d;
  logic                  flush_q, flush_d;
  logic                  halted_q, halted_d;

  logic                  z_eval;
  logic                  n_eval;
  logic                  cond;

  // Select the flag values the branch condition is evaluated against.
  always_comb begin
    z_eval = z_q;
    n_eval = n_q;
`ifdef PC_BRANCH_FLAG_BYPASS_EN
    if (flag_we_i) begin
      z_eval = z_in_i;
      n_eval = n_in_i;
    end
`else
`endif
  end

  // Decode br_op into a taken/not-taken condition; reserved codes never take.
  always_comb begin
    cond = 1'b0;
    unique case (br_op_i)
      OP_JUMP: cond = 1'b1;
      OP_BRZ:  cond = z_eval;
      OP_BRN:  cond = n_eval;
      OP_BRNZ: cond = ~z_eval;
      default: cond = 1'b0;
    endcase
  end

  // Next-state and registered-output logic for the sequencing FSM.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    z_d      = z_q;
    n_d      = n_q;
    taken_d  = 1'b0;
    flush_d  = flush_q;
    halted_d = halted_q;

    // Flags load independently of en; only HALT freezes them.
    if (state_q != ST_HALT && flag_we_i) begin
      z_d = z_in_i;
      n_d = n_in_i;
    end

    unique case (state_q)
      ST_RUN: begin
        if (halt_req_i) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
          flush_d  = 1'b0;
        end else if (en_i) begin
          if (br_valid_i && cond) begin
            pc_d    = target_i;
            taken_d = 1'b1;
            if (HAS_FLUSH) begin
              cnt_d   = FLUSH_LOAD;
              flush_d = 1'b1;
              state_d = ST_FLUSH;
            end
          end else begin
            pc_d = pc_q + PC_ONE;
          end
        end
      end
      ST_FLUSH: begin
        if (halt_req_i) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
          flush_d  = 1'b0;
          cnt_d    = '0;
        end else if (en_i) begin
          pc_d  = pc_q + PC_ONE;
          cnt_d = cnt_q - 4'd1;
          // Terminal count: this en cycle is the last one of the window.
          if (cnt_q == 4'd1) begin
            flush_d = 1'b0;
            state_d = ST_RUN;
          end
        end
      end
      ST_HALT: begin
        flush_d  = 1'b0;
        halted_d = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
        flush_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      cnt_q    <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      taken_q  <= 1'b0;
      flush_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      z_q      <= z_d;
      n_q      <= n_d;
      taken_q  <= taken_d;
      flush_q  <= flush_d;
      halted_q <= halted_d;
    end
  end

  assign pc_o     = pc_q;
  assign z_flag_o = z_q;
  assign n_flag_o = n_q;
  assign taken_o  = taken_q;
  assign flush_o  = flush_q;
  assign halted_o = halted_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Testbench for pc_branch_unit: directed scenarios followed by random
// stimulus, all compared against a behavioural model of the unit.

module tb_pc_branch_unit;

  localparam int unsigned PCW  = 32;
  localparam int unsigned FCYC = 2;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            en_i, flag_we_i, z_in_i, n_in_i, br_valid_i, halt_req_i;
  logic [2:0]      br_op_i;
  logic [PCW-1:0]  target_i;
  logic [PCW-1:0]  pc_o;
  logic            z_flag_o, n_flag_o, taken_o, flush_o, halted_o;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [PCW-1:0] m_pc;
  logic           m_z, m_n, m_taken, m_halted;
  int             m_flush_left;

  pc_branch_unit #(.PC_WIDTH(PCW), .RESET_PC('0), .FLUSH_CYCLES(FCYC)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en_i       (en_i),
    .flag_we_i  (flag_we_i),
    .z_in_i     (z_in_i),
    .n_in_i     (n_in_i),
    .br_valid_i (br_valid_i),
    .br_op_i    (br_op_i),
    .target_i   (target_i),
    .halt_req_i (halt_req_i),
    .pc_o       (pc_o),
    .z_flag_o   (z_flag_o),
    .n_flag_o   (n_flag_o),
    .taken_o    (taken_o),
    .flush_o    (flush_o),
    .halted_o   (halted_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [PCW-1:0] obs, input logic [PCW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = '0; m_z = 0; m_n = 0; m_taken = 0; m_halted = 0; m_flush_left = 0;
  endtask

  // One rising edge of the unit, described by its rules rather than its FSM.
  task automatic model_edge();
    logic cz, cn, take;
    cz = m_z; cn = m_n;
`ifdef PC_BRANCH_FLAG_BYPASS_EN
    if (flag_we_i) begin cz = z_in_i; cn = n_in_i; end
`endif
    take = br_valid_i && ((br_op_i == 3'd1) || (br_op_i == 3'd2 && cz) ||
                          (br_op_i == 3'd3 && cn) || (br_op_i == 3'd4 && !cz));
    if (!m_halted && flag_we_i) begin m_z = z_in_i; m_n = n_in_i; end
    m_taken = 0;
    if (m_halted) begin
    end else if (halt_req_i) begin
      m_halted = 1; m_flush_left = 0;
    end else if (m_flush_left > 0) begin
      if (en_i) begin m_pc = m_pc + 1; m_flush_left--; end
    end else if (en_i) begin
      if (take) begin
        m_pc = target_i; m_taken = 1; m_flush_left = FCYC;
      end else begin
        m_pc = m_pc + 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},     pc_o,     m_pc);
    chk({tag, ".z"},      PCW'(z_flag_o), PCW'(m_z));
    chk({tag, ".n"},      PCW'(n_flag_o), PCW'(m_n));
    chk({tag, ".taken"},  PCW'(taken_o),  PCW'(m_taken));
    chk({tag, ".flush"},  PCW'(flush_o),  PCW'(m_flush_left > 0));
    chk({tag, ".halted"}, PCW'(halted_o), PCW'(m_halted));
  endtask

  task automatic drive(input logic en, input logic fwe, input logic z, input logic n,
                       input logic bv, input logic [2:0] op, input logic [PCW-1:0] tgt,
                       input logic hr);
    en_i = en; flag_we_i = fwe; z_in_i = z; n_in_i = n;
    br_valid_i = bv; br_op_i = op; target_i = tgt; halt_req_i = hr;
  endtask

  task automatic step(input string tag);
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
    check_all(tag);
  endtask

  // Asynchronous reset applied mid-cycle, checked before any clock edge.
  task automatic do_reset(input string tag);
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1 model_reset();
    check_all(tag);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 3'd0, '0, 0);
    rst_ni = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    chk("reset.pc0", pc_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Sequential fetch, no branches
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 0, 3'd0, '0, 0);
      step("seq");
    end
    chk("seq.pc4", pc_o, 32'h4);

    // Flag write then BRZ on the registered flag
    drive(1, 1, 1, 0, 0, 3'd0, '0, 0);
    step("flagz");
    chk("flagz.pc5", pc_o, 32'h5);
    drive(1, 0, 0, 0, 1, 3'd2, 32'h40, 0);
    step("brz");
    chk("brz.pc", pc_o, 32'h40);
    chk("brz.taken", PCW'(taken_o), 32'h1);
    chk("brz.flush", PCW'(flush_o), 32'h1);
    drive(1, 0, 0, 0, 1, 3'd1, 32'h999, 0);
    step("fl1");
    chk("fl1.pc", pc_o, 32'h41);
    chk("fl1.taken", PCW'(taken_o), 32'h0);
    chk("fl1.flush", PCW'(flush_o), 32'h1);
    step("fl2");
    chk("fl2.pc", pc_o, 32'h42);
    chk("fl2.flush", PCW'(flush_o), 32'h0);

    // Same-cycle flag write and branch
    drive(1, 1, 0, 0, 0, 3'd0, '0, 0);
    step("clrz");
    drive(1, 1, 1, 0, 1, 3'd2, 32'h80, 0);
    step("bypass");
`ifdef PC_BRANCH_FLAG_BYPASS_EN
    chk("bypass.pc", pc_o, 32'h80);
`else
    chk("bypass.pc", pc_o, 32'h44);
`endif
    drive(1, 1, 0, 0, 0, 3'd0, '0, 0);
    step("clrflags");
    step("drain");

    // BRN not taken, BRNZ taken, reserved opcode as NOP
    drive(1, 0, 0, 0, 1, 3'd3, 32'h77, 0);
    step("brn");
    drive(1, 0, 0, 0, 1, 3'd4, 32'h20, 0);
    step("brnz");
    chk("brnz.pc", pc_o, 32'h20);
    drive(1, 0, 0, 0, 0, 3'd0, '0, 0);
    step("brnz.f1");
    step("brnz.f2");
    drive(1, 0, 0, 0, 1, 3'd7, 32'h55, 0);
    step("resv");
    chk("resv.pc", pc_o, 32'h23);

    // PC wrap, then halt beating a same-cycle jump
    drive(1, 0, 0, 0, 1, 3'd1, 32'hFFFF_FFFD, 0);
    step("jwrap");
    drive(1, 0, 0, 0, 0, 3'd0, '0, 0);
    step("jwrap.f1");
    step("jwrap.f2");
    chk("wrap.pre", pc_o, 32'hFFFF_FFFF);
    step("wrap");
    chk("wrap.pc", pc_o, 32'h0);
    drive(1, 0, 0, 0, 1, 3'd1, 32'h10, 1);
    step("halt");
    chk("halt.halted", PCW'(halted_o), 32'h1);
    chk("halt.pc", pc_o, 32'h0);
    chk("halt.taken", PCW'(taken_o), 32'h0);
    drive(1, 1, 1, 1, 1, 3'd1, 32'h10, 0);
    step("halt.hold");
    step("halt.hold2");

    // en=0 stretches the flush window; reset mid-flush clears it
    do_reset("rst.halt");
    drive(1, 0, 0, 0, 1, 3'd1, 32'h100, 0);
    step("j100");
    drive(0, 0, 0, 0, 0, 3'd0, '0, 0);
    for (int i = 0; i < 3; i++) step("stall");
    chk("stall.flush", PCW'(flush_o), 32'h1);
    chk("stall.pc", pc_o, 32'h100);
    drive(1, 0, 0, 0, 0, 3'd0, '0, 0);
    step("stall.go");
    chk("stall.go.flush", PCW'(flush_o), 32'h1);
    do_reset("rst.flush");
    chk("rst.flush.pc", pc_o, 32'h0);

    // Random stimulus against the model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 299) == 0 || (m_halted && $urandom_range(0, 7) == 0)) begin
        do_reset("rnd.rst");
      end
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            1'($urandom), 1'($urandom), 1'($urandom),
            3'($urandom), $urandom, $urandom_range(0, 149) == 0);
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
